fetch_pc_unit: RTL and testbench

Fetch-side PC sequencer. It receives the branch controller's redirect and squash outputs and issues instruction-memory reads. It owns the per-stage valid bits (fetch, rf_read, execute, writeback) and the instruction-register pipeline that feeds the rf_read and execute stages. It sits between the instruction memory and the branch/PC controller, and is the consumer of that controller's `branch_sig` / `pc_in_br` / `set_invalid_*` protocol.

---
 rtl/fetch_pc_unit_pkg.sv | 29 ++
 rtl/fetch_pc_unit_if.sv | 11 +
 rtl/fetch_pc_unit_ir_hold_buffer.sv | 36 +++
 rtl/fetch_pc_unit.sv | 91 +++++++++
 tb/tb_fetch_pc_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared types and constants for the fetch PC sequencer
package fetch_pc_unit_pkg;

    localparam int          PC_W             = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [15:0] PC_STEP          = 16'd2;

    typedef enum logic [1:0] {
        STAGE_FETCH     = 2'd0,
        STAGE_RF_READ   = 2'd1,
        STAGE_EXECUTE   = 2'd2,
        STAGE_WRITEBACK = 2'd3
    } stage_e;

    // Opcodes shared with the branch controller; nothing is decoded in this block.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_CALL = 4'h7;

    function automatic logic [15:0] next_seq_pc(input logic [15:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction memory read bus between fetch and memory
interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic [PC_W-1:0] mem_addr;
    logic            mem_rd;
    logic [PC_W-1:0] mem_rddata;

    modport master (output mem_addr, output mem_rd, input mem_rddata);
    modport slave  (input mem_addr, input mem_rd, output mem_rddata);
endinterface

// File: rtl/fetch_pc_unit_ir_hold_buffer.sv
// rtl/fetch_pc_unit_ir_hold_buffer.sv - keeps the rf_read instruction word stable across a stall
module fetch_pc_unit_ir_hold_buffer
    import fetch_pc_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic [PC_W-1:0] rddata_i,
    output logic [PC_W-1:0] ir_o
);

    logic            stall_q, stall_d;
    logic [PC_W-1:0] ir_hold_q, ir_hold_d;

    always_comb begin
        stall_d   = hold_i;
        ir_hold_d = ir_hold_q;
        // Capture only on the first held cycle; later cycles see the re-read fetch word.
        if (hold_i && !stall_q) begin
            ir_hold_d = rddata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q   <= 1'b0;
            ir_hold_q <= '0;
        end else begin
            stall_q   <= stall_d;
            ir_hold_q <= ir_hold_d;
        end
    end

    assign ir_o = stall_q ? ir_hold_q : rddata_i;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-side PC sequencer owning stage valids and the IR pipeline
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   branch_sig,
    input  logic [PC_W-1:0]        pc_in_br,
    input  logic                   set_invalid_sig_to_fetch,
    input  logic                   set_invalid_sig_to_rf_read,
    input  logic                   stall,
    fetch_pc_unit_if.master        imem,
    output logic [PC_W-1:0]        o_pc_out_in_fetch_stage,
    output logic [PC_W-1:0]        o_ir_rf_read,
    output logic [PC_W-1:0]        o_ir_out_in_execute_stage,
    output logic                   valid_in_fetch_stage,
    output logic                   valid_in_rf_read_stage,
    output logic                   valid_in_execute_stage,
    output logic                   valid_in_writeback_stage,
    output logic [PC_W-1:0]        o_redirect_cnt
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      valid_q, valid_d;
    logic [PC_W-1:0] ir_ex_q, ir_ex_d;
    logic [PC_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic            sq_r;
    logic            hold;

    // A squash of rf_read always wins over a load-use stall.
    assign sq_r = set_invalid_sig_to_rf_read;
    assign hold = stall & ~sq_r;

    fetch_pc_unit_ir_hold_buffer u_ir_hold_buffer (
        .clk_i    (clk),
        .rst_i    (reset),
        .hold_i   (hold),
        .rddata_i (imem.mem_rddata),
        .ir_o     (o_ir_rf_read)
    );

    always_comb begin
        pc_d           = pc_q;
        valid_d        = valid_q;
        ir_ex_d        = ir_ex_q;
        redirect_cnt_d = redirect_cnt_q;

        valid_d[STAGE_WRITEBACK] = valid_q[STAGE_EXECUTE];
        if (hold) begin
            valid_d[STAGE_EXECUTE] = 1'b0;
        end else begin
            if (valid_q[STAGE_FETCH]) begin
                pc_d = branch_sig ? pc_in_br : next_seq_pc(pc_q);
            end
            valid_d[STAGE_FETCH]   = 1'b1;
            valid_d[STAGE_RF_READ] = valid_q[STAGE_FETCH] & ~set_invalid_sig_to_fetch;
            valid_d[STAGE_EXECUTE] = valid_q[STAGE_RF_READ] & ~sq_r;
            ir_ex_d                = o_ir_rf_read;
            if (set_invalid_sig_to_fetch | sq_r) begin
                redirect_cnt_d = redirect_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            valid_q        <= '0;
            ir_ex_q        <= '0;
            redirect_cnt_q <= '0;
        end else begin
            pc_q           <= pc_d;
            valid_q        <= valid_d;
            ir_ex_q        <= ir_ex_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign imem.mem_addr              = pc_q;
    assign imem.mem_rd                = valid_q[STAGE_FETCH];
    assign o_pc_out_in_fetch_stage    = pc_q;
    assign o_ir_out_in_execute_stage  = ir_ex_q;
    assign valid_in_fetch_stage       = valid_q[STAGE_FETCH];
    assign valid_in_rf_read_stage     = valid_q[STAGE_RF_READ];
    assign valid_in_execute_stage     = valid_q[STAGE_EXECUTE];
    assign valid_in_writeback_stage   = valid_q[STAGE_WRITEBACK];
    assign o_redirect_cnt             = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        branch_sig;
    logic [15:0] pc_in_br;
    logic        sif;
    logic        sir;
    logic        stall;
    logic [15:0] pc_out, ir_rf, ir_ex, redirect_cnt;
    logic        v_f, v_r, v_e, v_w;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .branch_sig                 (branch_sig),
        .pc_in_br                   (pc_in_br),
        .set_invalid_sig_to_fetch   (sif),
        .set_invalid_sig_to_rf_read (sir),
        .stall                      (stall),
        .imem                       (bus),
        .o_pc_out_in_fetch_stage    (pc_out),
        .o_ir_rf_read               (ir_rf),
        .o_ir_out_in_execute_stage  (ir_ex),
        .valid_in_fetch_stage       (v_f),
        .valid_in_rf_read_stage     (v_r),
        .valid_in_execute_stage     (v_e),
        .valid_in_writeback_stage   (v_w),
        .o_redirect_cnt             (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Behavioural model: per-stage slots carrying a valid flag and the PC of the instruction.
    logic [15:0] m_pc;
    logic        m_v   [4];
    logic [15:0] m_spc [4];
    logic [15:0] m_cnt;
    bit          chk_en = 0;
    bit          ovr    = 0;
    int          cool   = 0;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst_v, input logic br, input logic [15:0] tgt,
                                input logic sf, input logic sr, input logic st);
        if (rst_v) begin
            m_pc  = RST_PC;
            m_cnt = '0;
            for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        end else if (st && !sr) begin
            m_v[3] = m_v[2];
            m_v[2] = 1'b0;
        end else begin
            if (sf || sr) m_cnt = m_cnt + 16'd1;
            m_v[3]   = m_v[2];
            m_v[2]   = m_v[1] && !sr;
            m_spc[2] = m_spc[1];
            m_v[1]   = m_v[0] && !sf;
            m_spc[1] = m_pc;
            if (m_v[0]) m_pc = br ? tgt : m_pc + 16'd2;
            m_v[0] = 1'b1;
        end
    endtask

    task automatic step(input logic rst_v, input logic br, input logic [15:0] tgt,
                        input logic sf, input logic sr, input logic st);
        logic [15:0] a;
        logic        rd;
        reset = rst_v; branch_sig = br; pc_in_br = tgt; sif = sf; sir = sr; stall = st;
        a  = bus.mem_addr;
        rd = bus.mem_rd;
        @(posedge clk);
        model_update(rst_v, br, tgt, sf, sr, st);
        #1;
        if (!ovr && rd) bus.mem_rddata = mem_fn(a);
        if (cool > 0) cool--;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_addr", bus.mem_addr, m_pc);
            chk("mdl_pc_out", pc_out, m_pc);
            chk("mdl_rd", {15'b0, bus.mem_rd}, {15'b0, m_v[0]});
            chk("mdl_valids", {12'b0, v_f, v_r, v_e, v_w}, {12'b0, m_v[0], m_v[1], m_v[2], m_v[3]});
            chk("mdl_cnt", redirect_cnt, m_cnt);
            if (!ovr && cool == 0) begin
                if (m_v[1]) chk("mdl_ir_rf", ir_rf, mem_fn(m_spc[1]));
                if (m_v[2]) chk("mdl_ir_ex", ir_ex, mem_fn(m_spc[2]));
            end
        end
    end

    initial begin
        bus.mem_rddata = 16'h0;
        reset = 1'b1; branch_sig = 1'b0; pc_in_br = 16'h0; sif = 1'b0; sir = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 1'b0;
            m_spc[i] = 16'h0;
        end
        m_pc = RST_PC; m_cnt = 16'h0;

        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk_en = 1;

        // cycle 0 after reset release
        chk("rst_rd", {15'b0, bus.mem_rd}, 16'h0);
        chk("rst_valids", {12'b0, v_f, v_r, v_e, v_w}, 16'h0);
        chk("rst_ir_rf_pass", ir_rf, bus.mem_rddata);
        chk("rst_cnt", redirect_cnt, 16'h0);

        // cycles 1..4: sequential addresses, valids ripple in
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("seq_addr", bus.mem_addr, 16'(2 * (i - 1)));
            chk("seq_valids", {12'b0, v_f, v_r, v_e, v_w},
                {12'b0, 1'b1, 1'(i >= 2), 1'(i >= 3), 1'(i >= 4)});
        end

        // prediction-only redirect applied in cycle 5
        idle();
        step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
        chk("pred_addr", bus.mem_addr, 16'h0040);
        chk("pred_valids", {12'b0, v_f, v_r, v_e, v_w}, 16'h000F);
        chk("pred_cnt", redirect_cnt, 16'h0);

        idle();
        idle();
        // execute mispredict: both squashes with a coincident stall
        step(1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b1);
        chk("mis_addr", bus.mem_addr, 16'h0100);
        chk("mis_v_r", {15'b0, v_r}, 16'h0);
        chk("mis_v_e", {15'b0, v_e}, 16'h0);
        chk("mis_cnt", redirect_cnt, 16'h1);

        idle();
        idle();
        // three-cycle stall with the memory word changing underneath
        ovr = 1;
        bus.mem_rddata = 16'hA5A5;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            bus.mem_rddata = 16'h1234;
            chk("stall_ir_rf", ir_rf, 16'hA5A5);
            chk("stall_addr", bus.mem_addr, 16'h0104);
            chk("stall_v_e", {15'b0, v_e}, 16'h0);
        end
        idle();
        chk("resume_ir_ex", ir_ex, 16'hA5A5);
        chk("resume_v_e", {15'b0, v_e}, 16'h1);
        chk("resume_addr", bus.mem_addr, 16'h0106);
        ovr  = 0;
        cool = 4;

        idle();
        idle();
        // PC wrap
        step(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        chk("wrap_addr0", bus.mem_addr, 16'hFFFE);
        idle();
        chk("wrap_addr1", bus.mem_addr, 16'h0000);
        idle();
        idle();

        // reset in the middle of a stall with a branch pending
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1);
        chk("mrst_valids", {12'b0, v_f, v_r, v_e, v_w}, 16'h0);
        chk("mrst_addr", bus.mem_addr, RST_PC);
        chk("mrst_cnt", redirect_cnt, 16'h0);

        for (int i = 0; i < 6; i++) idle();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
